// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds PC and IR, fetches one word per load_ir over a
// variable-latency req/ack memory handshake, and squashes fetches made stale by redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_ir,
  input  logic        load_pc,
  input  logic        clear_pc,
  input  logic [31:0] pc_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_read,
  output logic        ir_valid,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        redir;
  logic [31:0] redir_pc;

  // clear_pc outranks load_pc whenever both are asserted
  assign redir    = clear_pc | load_pc;
  assign redir_pc = clear_pc ? RESET_PC : pc_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      instr     <= 32'h0;
      instr_pc  <= RESET_PC;
      pc_read   <= RESET_PC + 32'd8;
      ir_valid  <= 1'b0;
      busy      <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      unique case (state)
        IDLE: begin
          if (redir) begin
            pc       <= redir_pc;
            ir_valid <= 1'b0;
          end
          if (load_ir) begin
            imem_req  <= 1'b1;
            imem_addr <= redir ? redir_pc : pc;
            busy      <= 1'b1;
            ir_valid  <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (redir) begin
            // A redirect squashes the outstanding fetch; if the ack is already
            // here, reissue immediately at the new target without dropping req.
            pc       <= redir_pc;
            ir_valid <= 1'b0;
            if (imem_ack) begin
              imem_addr <= redir_pc;
            end else begin
              state <= DISCARD;
            end
          end else if (imem_ack) begin
            instr     <= imem_rdata;
            instr_pc  <= imem_addr;
            pc_read   <= imem_addr + 32'd8;
            pc        <= pc + 32'd4;
            ir_valid  <= 1'b1;
            imem_req  <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        DISCARD: begin
          if (redir) begin
            pc <= redir_pc;
          end
          if (imem_ack) begin
            imem_addr <= redir ? redir_pc : pc;
            state     <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table plus hand-written
// sequences for address wrap and reset during an outstanding fetch.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_ir, load_pc, clear_pc;
  logic [31:0] pc_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr, instr_pc, pc_read;
  logic        ir_valid, busy;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .load_ir(load_ir), .load_pc(load_pc), .clear_pc(clear_pc),
    .pc_in(pc_in), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc), .pc_read(pc_read),
    .ir_valid(ir_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lir, lpc, cpc;
    logic [31:0] pcin;
    logic        ack;
    logic [31:0] rdata;
    logic        ereq;
    logic [31:0] eaddr;
    logic        ebusy, evalid;
    logic [31:0] einstr, eipc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic lir, lpc, cpc, input logic [31:0] pcin,
                     input logic ack, input logic [31:0] rdata,
                     input logic ereq, input logic [31:0] eaddr,
                     input logic ebusy, evalid, input logic [31:0] einstr, eipc);
    vec_t v;
    v.lir = lir; v.lpc = lpc; v.cpc = cpc; v.pcin = pcin; v.ack = ack; v.rdata = rdata;
    v.ereq = ereq; v.eaddr = eaddr; v.ebusy = ebusy; v.evalid = evalid;
    v.einstr = einstr; v.eipc = eipc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ereq, input logic [31:0] eaddr,
                         input logic ebusy, evalid, input logic [31:0] einstr, eipc);
    chk({tag, " imem_req"}, {31'h0, imem_req}, {31'h0, ereq});
    chk({tag, " imem_addr"}, imem_addr, eaddr);
    chk({tag, " busy"}, {31'h0, busy}, {31'h0, ebusy});
    chk({tag, " ir_valid"}, {31'h0, ir_valid}, {31'h0, evalid});
    chk({tag, " instr"}, instr, einstr);
    chk({tag, " instr_pc"}, instr_pc, eipc);
    chk({tag, " pc_read"}, pc_read, eipc + 32'd8);
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic step(input logic lir, lpc, cpc, input logic [31:0] pcin,
                      input logic ack, input logic [31:0] rdata);
    load_ir = lir; load_pc = lpc; clear_pc = cpc; pc_in = pcin;
    imem_ack = ack; imem_rdata = rdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk_all("reset", 0, 32'h0, 0, 0, 32'h0, 32'h0);
    rst = 1'b0;

    // fetch at 0, ack in first request cycle
    add(1,0,0,0,0,0,                     1,32'h0,1,0,32'h0,32'h0);
    add(0,0,0,0,1,32'hE3A0_1005,         0,32'h0,0,1,32'hE3A0_1005,32'h0);
    // fetch at 4, ack latency 3, load_ir during busy ignored
    add(1,0,0,0,0,0,                     1,32'h4,1,0,32'hE3A0_1005,32'h0);
    add(0,0,0,0,0,0,                     1,32'h4,1,0,32'hE3A0_1005,32'h0);
    add(1,0,0,0,0,0,                     1,32'h4,1,0,32'hE3A0_1005,32'h0);
    add(0,0,0,0,0,0,                     1,32'h4,1,0,32'hE3A0_1005,32'h0);
    add(0,0,0,0,1,32'h1111_1111,         0,32'h4,0,1,32'h1111_1111,32'h4);
    // fetch at 8, ack latency 7
    add(1,0,0,0,0,0,                     1,32'h8,1,0,32'h1111_1111,32'h4);
    for (int i = 0; i < 7; i++)
      add(logic'(i % 2),0,0,0,0,0,       1,32'h8,1,0,32'h1111_1111,32'h4);
    add(0,0,0,0,1,32'h2222_2222,         0,32'h8,0,1,32'h2222_2222,32'h8);
    // fetch at C, redirect to 0x100 two cycles in, old ack at k=4 dropped
    add(1,0,0,0,0,0,                     1,32'hC,1,0,32'h2222_2222,32'h8);
    add(0,0,0,0,0,0,                     1,32'hC,1,0,32'h2222_2222,32'h8);
    add(0,1,0,32'h100,0,0,               1,32'hC,1,0,32'h2222_2222,32'h8);
    add(0,0,0,0,0,0,                     1,32'hC,1,0,32'h2222_2222,32'h8);
    add(1,0,0,0,0,0,                     1,32'hC,1,0,32'h2222_2222,32'h8);
    add(0,0,0,0,1,32'hDEAD_BEEF,         1,32'h100,1,0,32'h2222_2222,32'h8);
    add(0,0,0,0,1,32'h3333_3333,         0,32'h100,0,1,32'h3333_3333,32'h100);
    // fetch at 0x104, redirect to 0x200 with ack in the same cycle
    add(1,0,0,0,0,0,                     1,32'h104,1,0,32'h3333_3333,32'h100);
    add(0,1,0,32'h200,1,32'hBAD0_BAD0,   1,32'h200,1,0,32'h3333_3333,32'h100);
    add(0,0,0,0,1,32'h4444_4444,         0,32'h200,0,1,32'h4444_4444,32'h200);
    // clear_pc beats load_pc in IDLE; redirect alone clears ir_valid
    add(0,1,1,32'h500,0,0,               0,32'h200,0,0,32'h4444_4444,32'h200);
    add(1,0,0,0,0,0,                     1,32'h0,1,0,32'h4444_4444,32'h200);
    add(0,0,0,0,1,32'h5555_5555,         0,32'h0,0,1,32'h5555_5555,32'h0);
    // redirect together with load_ir in IDLE fetches from the new PC
    add(1,1,0,32'h300,0,0,               1,32'h300,1,0,32'h5555_5555,32'h0);
    add(0,0,0,0,1,32'h6666_6666,         0,32'h300,0,1,32'h6666_6666,32'h300);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].lir, vecs[i].lpc, vecs[i].cpc, vecs[i].pcin, vecs[i].ack, vecs[i].rdata);
      chk_all($sformatf("row%0d", i), vecs[i].ereq, vecs[i].eaddr, vecs[i].ebusy,
              vecs[i].evalid, vecs[i].einstr, vecs[i].eipc);
    end

    // PC wrap at the top of the address space
    step(0, 1, 0, 32'hFFFF_FFFC, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("wrap addr", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 1, 32'h7777_7777);
    chk("wrap instr_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap pc_read", pc_read, 32'h0000_0004);
    chk("wrap ir_valid", {31'h0, ir_valid}, 32'h1);
    step(1, 0, 0, 0, 0, 0);
    chk("wrap next addr", imem_addr, 32'h0);
    step(0, 0, 0, 0, 1, 32'h8888_8888);
    chk("wrap next instr", instr, 32'h8888_8888);

    // reset in the middle of an outstanding fetch, then a stale ack
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("midfetch req", {31'h0, imem_req}, 32'h1);
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    chk_all("rst mid", 0, 32'h0, 0, 0, 32'h0, 32'h0);
    rst = 1'b0;
    step(0, 0, 0, 0, 1, 32'h9999_9999);
    chk_all("stale ack", 0, 32'h0, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 0, 0, 0);
    chk_all("post rst fetch", 1, 32'h0, 1, 0, 32'h0, 32'h0);
    step(0, 0, 0, 0, 1, 32'hAAAA_AAAA);
    chk_all("post rst done", 0, 32'h0, 0, 1, 32'hAAAA_AAAA, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
